// File: rtl/mine_placer.sv
// mine_placer: places NUM_MINES random mines avoiding a safe cell, then serves registered cell/neighbour queries
module mine_placer #(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int NUM_MINES = 10,
   parameter int IDX_W     = 8
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rand_num,
   input  logic                 start,
   input  logic [IDX_W-1:0]     safe_idx,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_W-1:0]     mine_cnt,
   output logic [ROWS*COLS-1:0] mine_map,
   input  logic [IDX_W-1:0]     query_idx,
   output logic                 query_mine,
   output logic [3:0]           query_adj
);
   localparam int N = ROWS*COLS;
   typedef enum logic [1:0] {IDLE, PLACE, DONE} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] safe_q, safe_d, cnt_q, cnt_d;
   logic [N-1:0] map_q, map_d;
   logic qmine_q, qmine_d;
   logic [3:0] qadj_q, qadj_d;
   logic [255:0] map_ext;
   logic accept, go;
   int qrow, qcol;
   assign map_ext = 256'(map_q);
   always_comb begin
      accept  = state_q == PLACE && int'(rand_num) < N && !map_ext[rand_num] && int'(rand_num) != int'(safe_q);
      go      = start && state_q != PLACE;
      state_d = go ? PLACE : (accept && cnt_q == IDX_W'(NUM_MINES-1)) ? DONE : state_q;
      safe_d  = go ? safe_idx : safe_q;
      cnt_d   = go ? '0 : accept ? cnt_q + IDX_W'(1) : cnt_q;
      map_d   = go ? '0 : accept ? (map_q | (N'(1) << rand_num)) : map_q;
   end
   always_comb begin
      qrow    = int'(query_idx) / COLS;
      qcol    = int'(query_idx) % COLS;
      qmine_d = int'(query_idx) < N && map_ext[8'(query_idx)];
      qadj_d  = '0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && int'(query_idx) < N &&
                qrow+dr >= 0 && qrow+dr < ROWS && qcol+dc >= 0 && qcol+dc < COLS)
               qadj_d = qadj_d + {3'b0, map_ext[8'((qrow+dr)*COLS + qcol+dc)]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         safe_q  <= '0;
         cnt_q   <= '0;
         map_q   <= '0;
         qmine_q <= 1'b0;
         qadj_q  <= '0;
      end else begin
         state_q <= state_d;
         safe_q  <= safe_d;
         cnt_q   <= cnt_d;
         map_q   <= map_d;
         qmine_q <= qmine_d;
         qadj_q  <= qadj_d;
      end
   end
   assign busy       = state_q == PLACE;
   assign done       = state_q == DONE;
   assign mine_cnt   = cnt_q;
   assign mine_map   = map_q;
   assign query_mine = qmine_q;
   assign query_adj  = qadj_q;
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: directed and LFSR-soak checks of mine placement and neighbour queries
module tb_mine_placer;
   localparam int NM = 3;
   logic clk = 0, rst = 0, start = 0, busy, done, query_mine;
   logic [7:0] rand_num = 0, safe_idx = 0, query_idx = 0, mine_cnt;
   logic [63:0] mine_map;
   logic [3:0] query_adj;
   int n_cmp = 0, n_bad = 0;

   mine_placer #(.ROWS(8), .COLS(8), .NUM_MINES(NM), .IDX_W(8)) dut (
      .clk(clk), .rst(rst), .rand_num(rand_num), .start(start), .safe_idx(safe_idx),
      .busy(busy), .done(done), .mine_cnt(mine_cnt), .mine_map(mine_map),
      .query_idx(query_idx), .query_mine(query_mine), .query_adj(query_adj));

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic place(input int v);
      rand_num = v[7:0];
      cyc();
   endtask

   task automatic begin_game(input int s);
      safe_idx = s[7:0];
      rand_num = 0;
      start = 1;
      cyc();
      start = 0;
   endtask

   function automatic int madj(input logic [63:0] m, input int i);
      int r = i / 8, c = i % 8, s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
               s += m[(r+dr)*8 + c+dc];
      return s;
   endfunction

   task automatic test_reset;
      rst = 1; cyc(); cyc(); rst = 0;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags busy/done=%b want 00", {busy, done}); end
      n_cmp++; if (mine_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", mine_cnt); end
      n_cmp++; if (mine_map !== 64'd0) begin n_bad++; $display("FAIL reset_map got %h want 0", mine_map); end
      n_cmp++; if ({query_mine, query_adj} !== 5'd0) begin n_bad++; $display("FAIL reset_query got %b want 0", {query_mine, query_adj}); end
      begin_game(5);
      place(3);
      n_cmp++; if (mine_cnt !== 8'd1) begin n_bad++; $display("FAIL pre_rst_cnt got %0d want 1", mine_cnt); end
      rst = 1; cyc(); cyc(); rst = 0;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL place_rst_flags got %b want 00", {busy, done}); end
      n_cmp++; if (mine_cnt !== 8'd0 || mine_map !== 64'd0) begin n_bad++; $display("FAIL place_rst_state cnt=%0d map=%h want 0/0", mine_cnt, mine_map); end
      rst = 1; start = 1; cyc(); rst = 0; start = 0;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_beats_start busy=%b want 0", busy); end
   endtask

   task automatic test_directed;
      int seq[5] = '{3, 17, 200, 3, 63};
      int ecnt[5] = '{1, 2, 2, 2, 3};
      begin_game(5);
      n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL start_flags got %b want 10", {busy, done}); end
      for (int i = 0; i < 5; i++) begin
         place(seq[i]);
         n_cmp++; if (mine_cnt !== 8'(ecnt[i])) begin n_bad++; $display("FAIL dir_cnt[%0d] got %0d want %0d", i, mine_cnt, ecnt[i]); end
         n_cmp++; if (done !== (i == 4)) begin n_bad++; $display("FAIL dir_done[%0d] got %b want %b", i, done, i == 4); end
      end
      n_cmp++; if (mine_map !== 64'h8000_0000_0002_0008) begin n_bad++; $display("FAIL dir_map got %h want 8000000000020008", mine_map); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dir_busy got %b want 0", busy); end
      place(5);
      n_cmp++; if (mine_map !== 64'h8000_0000_0002_0008 || mine_cnt !== 8'd3) begin n_bad++; $display("FAIL done_frozen map=%h cnt=%0d", mine_map, mine_cnt); end
   endtask

   task automatic test_safe;
      begin_game(9);
      for (int i = 0; i < 20; i++) begin
         place(9);
         n_cmp++; if (mine_cnt !== 8'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL safe_hold[%0d] cnt=%0d busy=%b want 0/1", i, mine_cnt, busy); end
      end
      place(10);
      n_cmp++; if (mine_cnt !== 8'd1) begin n_bad++; $display("FAIL safe_then_10 got %0d want 1", mine_cnt); end
   endtask

   task automatic test_restart;
      safe_idx = 0; rand_num = 9; start = 1; cyc(); start = 0;
      n_cmp++; if (mine_cnt !== 8'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL start_in_place cnt=%0d busy=%b want 1/1", mine_cnt, busy); end
      place(0);
      n_cmp++; if (mine_cnt !== 8'd2) begin n_bad++; $display("FAIL safe_not_relatched got %0d want 2", mine_cnt); end
      place(11);
      n_cmp++; if (done !== 1'b1 || mine_map !== 64'h0000_0000_0000_0C01) begin n_bad++; $display("FAIL restart_fill done=%b map=%h want 1/c01", done, mine_map); end
      begin_game(0);
      n_cmp++; if ({busy, done} !== 2'b10 || mine_map !== 64'd0 || mine_cnt !== 8'd0) begin n_bad++; $display("FAIL restart_done flags=%b map=%h cnt=%0d", {busy, done}, mine_map, mine_cnt); end
   endtask

   task automatic test_adjacency;
      int qi[10] = '{0, 9, 64, 255, 8, 15, 63, 62, 7, 56};
      int em[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
      int ea[10] = '{3, 2, 0, 0, 0, 1, 1, 0, 0, 0};
      place(1); place(8); place(9);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL adj_setup1 done=%b want 1", done); end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            begin_game(0); place(7); place(60); place(62);
            n_cmp++; if (mine_map !== 64'h5000_0000_0000_0080) begin n_bad++; $display("FAIL adj_setup2 map=%h want 5000000000000080", mine_map); end
         end
         query_idx = qi[i][7:0];
         cyc();
         n_cmp++; if (query_mine !== em[i][0] || query_adj !== 4'(ea[i])) begin n_bad++; $display("FAIL adj_q%0d mine/adj=%b/%0d want %0d/%0d", qi[i], query_mine, query_adj, em[i], ea[i]); end
      end
   endtask

   task automatic test_soak;
      logic [7:0] lfsr = 8'hA5;
      logic [63:0] m;
      int s, k, t;
      for (int g = 0; g < 50; g++) begin
         s = $urandom_range(63);
         begin_game(s);
         m = '0; k = 0; t = 0;
         while (k < NM && t < 3000) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rand_num = lfsr;
            if (lfsr < 64 && !m[lfsr[5:0]] && int'(lfsr) != s) begin m[lfsr[5:0]] = 1; k++; end
            cyc();
            t++;
         end
         n_cmp++; if (k !== NM || done !== 1'b1) begin n_bad++; $display("FAIL soak_done g%0d done=%b placed=%0d want 1/%0d", g, done, k, NM); end
         n_cmp++; if (mine_map !== m || $countones(mine_map) != NM || mine_map[s] !== 1'b0) begin n_bad++; $display("FAIL soak_map g%0d got %h want %h safe=%0d", g, mine_map, m, s); end
         for (int q = 0; q < 64; q++) begin
            query_idx = q[7:0];
            cyc();
            n_cmp++; if (query_mine !== m[q] || query_adj !== 4'(madj(m, q))) begin n_bad++; $display("FAIL soak_q g%0d c%0d got %b/%0d want %b/%0d", g, q, query_mine, query_adj, m[q], madj(m, q)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_safe();
      test_restart();
      test_adjacency();
      test_soak();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
